dcache_writeback_unit: RTL and testbench

DCACHE_WRITEBACK_UNIT -- requirements
Module: dcache_writeback_unit

---
 rtl/dcache_writeback_unit.sv | 109 ++++++++++
 tb/tb_dcache_writeback_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_writeback_unit.sv
// Evicts one data-cache line: reads it from the data store, then streams it to memory
// as a sequence of BEAT_WIDTH beats, with valid/ready flow control on the memory side.
module dcache_writeback_unit #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned NUM_WORDS   = 256,
  parameter int unsigned BEAT_WIDTH  = 64,
  parameter int unsigned PADDR_WIDTH = 56
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wb_req_i,
  input  logic [$clog2(NUM_WORDS)-1:0] wb_index_i,
  input  logic [PADDR_WIDTH-1:0]       wb_paddr_i,
  output logic                         wb_ack_o,
  output logic                         wb_done_o,
  output logic                         busy_o,
  output logic                         ds_en_o,
  output logic                         ds_we_o,
  output logic [DATA_WIDTH/8-1:0]      ds_write_byte_o,
  output logic [$clog2(NUM_WORDS)-1:0] ds_addr_o,
  input  logic [DATA_WIDTH-1:0]        ds_rdata_i,
  output logic                         mem_valid_o,
  input  logic                         mem_ready_i,
  output logic [PADDR_WIDTH-1:0]       mem_paddr_o,
  output logic [BEAT_WIDTH-1:0]        mem_data_o,
  output logic                         mem_last_o
);

  localparam int unsigned IDX_W   = $clog2(NUM_WORDS);
  localparam int unsigned N_BEATS = DATA_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int unsigned OFF_W   = $clog2(DATA_WIDTH / 8);

  localparam logic [PADDR_WIDTH-1:0] LINE_MASK  = ~((PADDR_WIDTH'(1) << OFF_W) - PADDR_WIDTH'(1));
  localparam logic [PADDR_WIDTH-1:0] BEAT_BYTES = PADDR_WIDTH'(BEAT_WIDTH / 8);
  localparam logic [CNT_W-1:0]       LAST_BEAT  = CNT_W'(N_BEATS - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] READ    = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] SEND    = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]             state_q;
  logic [IDX_W-1:0]       index_q;
  logic [PADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]  line_q;
  logic [CNT_W-1:0]       beat_q;

  logic                   in_send;
  logic                   at_last;
  logic [BEAT_WIDTH-1:0]  beat_data;

  assign in_send   = (state_q == SEND);
  assign at_last   = (beat_q == LAST_BEAT);
  assign beat_data = BEAT_WIDTH'(line_q >> (32'(beat_q) * BEAT_WIDTH));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      index_q <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_req_i) begin
            index_q <= wb_index_i;
            addr_q  <= wb_paddr_i & LINE_MASK;
            state_q <= READ;
          end
        end
        READ: state_q <= CAPTURE;
        // Store has one cycle of read latency, so the line is valid here.
        CAPTURE: begin
          line_q  <= ds_rdata_i;
          beat_q  <= '0;
          state_q <= SEND;
        end
        SEND: begin
          if (mem_ready_i) begin
            if (at_last) state_q <= DONE;
            else         beat_q  <= beat_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ack is gated by reset so every output reads zero while reset is held.
  assign wb_ack_o        = rst_ni && (state_q == IDLE) && wb_req_i;
  assign wb_done_o       = (state_q == DONE);
  assign busy_o          = (state_q != IDLE);

  assign ds_en_o         = (state_q == READ);
  assign ds_we_o         = 1'b0;
  assign ds_write_byte_o = '0;
  assign ds_addr_o       = ds_en_o ? index_q : '0;

  // Beat outputs depend only on registered state, so they hold while ready is low.
  assign mem_valid_o     = in_send;
  assign mem_last_o      = in_send && at_last;
  assign mem_data_o      = in_send ? beat_data : '0;
  assign mem_paddr_o     = in_send ? (addr_q + PADDR_WIDTH'(beat_q) * BEAT_BYTES) : '0;

endmodule

// File: tb/tb_dcache_writeback_unit.sv
// Directed bench for dcache_writeback_unit: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares every transferred beat and watches handshake rules.
module tb_dcache_writeback_unit;

  typedef struct packed {
    logic [55:0] paddr;
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  always #5 clk = ~clk;

  // 128/64 instance
  logic         wb_req = 1'b0;
  logic [7:0]   wb_index = '0;
  logic [55:0]  wb_paddr = '0;
  logic         wb_ack, wb_done, busy, ds_en, ds_we;
  logic [15:0]  ds_wbyte;
  logic [7:0]   ds_addr;
  logic [127:0] ds_rdata = '0;
  logic         mem_valid, mem_last;
  logic         mem_ready = 1'b1;
  logic [55:0]  mem_paddr;
  logic [63:0]  mem_data;

  // 64/64 instance
  logic         wb_req2 = 1'b0;
  logic [3:0]   wb_index2 = '0;
  logic [55:0]  wb_paddr2 = '0;
  logic         wb_ack2, wb_done2, busy2, ds_en2, ds_we2;
  logic [7:0]   ds_wbyte2;
  logic [3:0]   ds_addr2;
  logic [63:0]  ds_rdata2 = '0;
  logic         mem_valid2, mem_last2;
  logic         mem_ready2 = 1'b1;
  logic [55:0]  mem_paddr2;
  logic [63:0]  mem_data2;

  dcache_writeback_unit #(.DATA_WIDTH(128), .NUM_WORDS(256), .BEAT_WIDTH(64), .PADDR_WIDTH(56)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wb_req_i(wb_req), .wb_index_i(wb_index), .wb_paddr_i(wb_paddr),
    .wb_ack_o(wb_ack), .wb_done_o(wb_done), .busy_o(busy), .ds_en_o(ds_en), .ds_we_o(ds_we),
    .ds_write_byte_o(ds_wbyte), .ds_addr_o(ds_addr), .ds_rdata_i(ds_rdata),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_paddr_o(mem_paddr),
    .mem_data_o(mem_data), .mem_last_o(mem_last));

  dcache_writeback_unit #(.DATA_WIDTH(64), .NUM_WORDS(16), .BEAT_WIDTH(64), .PADDR_WIDTH(56)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .wb_req_i(wb_req2), .wb_index_i(wb_index2), .wb_paddr_i(wb_paddr2),
    .wb_ack_o(wb_ack2), .wb_done_o(wb_done2), .busy_o(busy2), .ds_en_o(ds_en2), .ds_we_o(ds_we2),
    .ds_write_byte_o(ds_wbyte2), .ds_addr_o(ds_addr2), .ds_rdata_i(ds_rdata2),
    .mem_valid_o(mem_valid2), .mem_ready_i(mem_ready2), .mem_paddr_o(mem_paddr2),
    .mem_data_o(mem_data2), .mem_last_o(mem_last2));

  // Data store models with one-cycle read latency
  logic [127:0] store [256];
  logic [63:0]  store2 [16];
  always @(posedge clk) if (ds_en) ds_rdata <= store[ds_addr];
  always @(posedge clk) if (ds_en2) ds_rdata2 <= store2[ds_addr2];

  int    n_chk = 0;
  int    n_fail = 0;
  beat_t exp_q[$];
  int    exp_acks = 0, exp_done = 0;
  int    ack_cnt = 0, done_cnt = 0, en_cnt = 0, we_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  logic        p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0, p_lastx = 1'b0;
  logic [63:0] p_data = '0;
  logic [55:0] p_paddr = '0;
  always @(negedge clk) begin : mon
    beat_t e;
    if (!rst_n) begin
      p_valid = 1'b0; p_ready = 1'b0; p_lastx = 1'b0;
    end else begin
      if (p_valid && !p_ready)
        chk("hold_stable", {mem_valid, mem_paddr, mem_data, mem_last}, {1'b1, p_paddr, p_data, p_last});
      if (p_lastx || wb_done)
        chk("done_after_last", wb_done, p_lastx);
      if (mem_valid && mem_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {mem_paddr, mem_data, mem_last}, '0);
        else begin
          e = exp_q.pop_front();
          chk("beat", {mem_paddr, mem_data, mem_last}, e);
        end
      end
      if (ds_en) en_cnt++;
      if (ds_we || ds_wbyte != '0) we_bad++;
      if (wb_ack) ack_cnt++;
      if (wb_done) done_cnt++;
      p_valid = mem_valid; p_ready = mem_ready; p_last = mem_last;
      p_data = mem_data; p_paddr = mem_paddr;
      p_lastx = mem_valid && mem_ready && mem_last;
    end
  end

  task automatic push_line(input logic [7:0] idx, input logic [55:0] pa);
    logic [55:0] base;
    base = pa & ~56'hF;
    exp_q.push_back({base, store[idx][63:0], 1'b0});
    exp_q.push_back({base + 56'd8, store[idx][127:64], 1'b1});
  endtask

  task automatic wait_ack(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_ack) break;
    end
    chk(name, wb_ack, 1'b1);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wb_done) break;
    end
    chk(name, wb_done, 1'b1);
  endtask

  task automatic run_wb(input logic [7:0] idx, input logic [55:0] pa, input int stall, input bit timed);
    push_line(idx, pa);
    exp_acks++; exp_done++;
    mem_ready = (stall == 0);
    wb_index = idx; wb_paddr = pa; wb_req = 1'b1;
    wait_ack("ack");
    @(posedge clk); #1 wb_req = 1'b0;
    if (timed) begin
      @(negedge clk);
      chk("read_cycle", {ds_en, ds_we, ds_addr, busy, wb_ack}, {1'b1, 1'b0, idx, 1'b1, 1'b0});
      @(negedge clk);
      chk("capture_cycle", {ds_en, mem_valid, busy}, {1'b0, 1'b0, 1'b1});
      @(negedge clk);
      chk("beat0_cycle3", mem_valid, 1'b1);
    end
    if (stall > 0) begin
      for (int i = 0; i < 20; i++) begin
        if (mem_valid) break;
        @(negedge clk);
      end
      chk("stall_valid_seen", mem_valid, 1'b1);
      repeat (stall) @(posedge clk);
      #1 mem_ready = 1'b1;
    end
    wait_done("done");
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) store[i] = '0;
    for (int i = 0; i < 16; i++) store2[i] = '0;
    store[5]  = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    store[9]  = {64'hA5A5_A5A5_5A5A_5A5A, 64'h3C3C_3C3C_C3C3_C3C3};
    store[12] = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    store2[3] = 64'hDEAD_BEEF_0123_4567;

    // Reset state, with a request pending to confirm ack stays low
    wb_req = 1'b1; wb_index = 8'd5; wb_paddr = 56'h8000_0040;
    #12;
    chk("reset_ctrl", {wb_ack, wb_done, busy, ds_en, ds_we, ds_wbyte, ds_addr, mem_valid, mem_last}, '0);
    chk("reset_data", {mem_paddr, mem_data}, '0);
    wb_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic, with cycle timing
    run_wb(8'd5, 56'h8000_0040, 0, 1'b1);
    // Backpressure on beat 0
    run_wb(8'd9, 56'h8000_0100, 3, 1'b0);
    // Unaligned address
    run_wb(8'd5, 56'h8000_004C, 0, 1'b0);

    // Held request: two back-to-back writebacks, second ack only from IDLE
    push_line(8'd12, 56'h8000_1230);
    push_line(8'd12, 56'h8000_1230);
    exp_acks += 2; exp_done += 2;
    mem_ready = 1'b1;
    wb_index = 8'd12; wb_paddr = 56'h8000_1230; wb_req = 1'b1;
    wait_ack("held_ack1");
    wait_done("held_done1");
    chk("held_no_ack_in_done", wb_ack, 1'b0);
    @(negedge clk);
    chk("held_ack2_idle", {wb_ack, busy}, {1'b1, 1'b0});
    wait_done("held_done2");
    @(posedge clk); #1 wb_req = 1'b0;

    // Reset after beat 0 has transferred
    exp_q.push_back({56'h8000_0080, store[9][63:0], 1'b0});
    exp_acks++;
    mem_ready = 1'b1;
    wb_index = 8'd9; wb_paddr = 56'h8000_0080; wb_req = 1'b1;
    wait_ack("rst_ack");
    @(posedge clk); #1 wb_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_valid) break;
    end
    chk("rst_beat0_seen", {mem_valid, mem_last}, {1'b1, 1'b0});
    @(posedge clk); #1 rst_n = 1'b0; wb_req = 1'b1;
    #1;
    chk("midsend_rst_ctrl", {wb_ack, wb_done, busy, ds_en, ds_we, ds_wbyte, ds_addr, mem_valid, mem_last}, '0);
    chk("midsend_rst_data", {mem_paddr, mem_data}, '0);
    wb_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // Normal operation after reset
    run_wb(8'd12, 56'h8000_2000, 0, 1'b0);

    // Single-beat configuration
    mem_ready2 = 1'b1;
    wb_index2 = 4'd3; wb_paddr2 = 56'h1000_0013; wb_req2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_ack2) break;
    end
    chk("w64_ack", wb_ack2, 1'b1);
    @(posedge clk); #1 wb_req2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_valid2) break;
    end
    chk("w64_beat", {mem_valid2, mem_paddr2, mem_data2, mem_last2},
        {1'b1, 56'h1000_0010, 64'hDEAD_BEEF_0123_4567, 1'b1});
    @(negedge clk);
    chk("w64_done", {wb_done2, mem_valid2, busy2}, {1'b1, 1'b0, 1'b1});
    @(negedge clk);
    chk("w64_idle", {wb_done2, busy2}, {1'b0, 1'b0});

    repeat (3) @(negedge clk);
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    chk("ack_count", 128'(ack_cnt), 128'(exp_acks));
    chk("done_count", 128'(done_cnt), 128'(exp_done));
    chk("ds_en_count", 128'(en_cnt), 128'(exp_acks));
    chk("never_writes", 128'(we_bad), 128'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
